surfturf_cmd_builder: RTL
=========================

SURFTURF_CMD_BUILDER -- requirements
Module: surfturf_cmd_builder

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 8, meaning sysclk cycles per command frame (legal range 2..255).
REQ-002 SHALL have port sysclk_i  input  1  system clock; all logic runs on its rising edge.
REQ-003 SHALL have port sysrst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port disable_rxclk_i  input  1  link disabled; already synchronous to sysclk_i.
REQ-005 SHALL have ports fw_tdata/fw_tvalid/fw_tready  input/input/output  8/1/1  firmware byte stream, AXI4-Stream minimal.
REQ-006 SHALL have port fw_mark_i  input  2  firmware mark request bits.
REQ-007 SHALL have port fw_marked_o  output  1  pulse: current marks were sent.
REQ-008 SHALL have ports runcmd_tdata/runcmd_tvalid/runcmd_tready  input/input/output  `RACKBUS_RUNCMD_BITS (2)/1/1  run command stream.
REQ-009 SHALL have ports trig_tdata/trig_tvalid/trig_tready  input/input/output  `RACKBUS_TRIG_BITS (15)/1/1  trigger stream.
REQ-010 SHALL have ports cmd_o/cmd_valid_o  output/output  32/1  command word to serializer; valid is a 1-cycle strobe.

Function
REQ-011 SHALL run a frame counter 0..FRAME_LEN-1 that wraps to 0; the cycle with count FRAME_LEN-1 is the load cycle.
REQ-012 SHALL drive each tready high only on the load cycle, only when its tvalid is high and disable_rxclk_i is low; all tready are low on every other cycle.
REQ-013 SHALL accept at most one beat per stream per frame; fw, runcmd and trig beats are all accepted together in the same load cycle when all are valid.
REQ-014 SHALL build the word as: [14:0] trig (0 if none accepted), [16:15] runcmd (0 if none), [24:17] fw byte (0 if none), [25] fw byte present, [27:26] fw_mark_i sampled on load cycle, [30:28] frame sequence, [31] per REQ-024.
REQ-015 SHALL register cmd_o and pulse cmd_valid_o on the cycle after the load cycle (latency 1 from acceptance); cmd_o holds between strobes.
REQ-016 SHALL pulse fw_marked_o for one cycle, coincident with cmd_valid_o, when the loaded word has a nonzero mark field.
REQ-017 SHALL increment the 3-bit sequence modulo 8 after every non-idle load; 7 wraps to 0.
REQ-018 SHALL, with disable_rxclk_i high on the load cycle, load the idle word 0x00000000, still pulse cmd_valid_o, hold all tready low, leave the sequence unchanged and keep fw_marked_o low.
REQ-019 SHALL leave the frame counter free-running regardless of disable_rxclk_i or stream activity.
REQ-020 SHALL never drop a beat: a tvalid beat not accepted stays pending upstream until a later load cycle.

Reset
REQ-021 SHALL, on sysrst_n_i low, asynchronously clear the frame counter, the sequence, cmd_o (0x00000000), cmd_valid_o, fw_marked_o and all tready.
REQ-022 SHALL, on reset release, produce the first load cycle FRAME_LEN-1 cycles after the first active edge.
REQ-023 SHALL, on reset mid-frame, discard the partial frame; no tready is asserted for it and no word is emitted.

Configuration
REQ-024 SHALL, with `CMD_PARITY_EN defined, drive bit 31 so that cmd_o[31:0] has even parity; without it, bit 31 SHALL be 0.

Structure
REQ-025 SHALL take field offsets/widths, the idle word and the sequence width from package surfturf_cmd_pkg; the RUNCMD/TRIG widths come from rackbus.vh.
REQ-026 SHALL implement the frame counter and load-cycle strobe in sub-module surfturf_cmd_frame_timer.

Verification
REQ-027 SHALL cover: FRAME_LEN=8, trig 0x1234 valid only -> trig_tready high at load, cmd_o=0x00001234 | seq<<28 (plus parity), strobe at next cycle.
REQ-028 SHALL cover: fw 0xA5, runcmd 2, trig 0x7FFF all valid at once -> all three tready in the same cycle, cmd_o[24:17]=0xA5, [25]=1, [16:15]=2, [14:0]=0x7FFF.
REQ-029 SHALL cover: fw_mark_i=2'b01 with no fw data -> cmd_o[27:26]=01, fw_marked_o pulses once with cmd_valid_o.
REQ-030 SHALL cover: disable_rxclk_i high for 3 frames with all streams valid -> three idle words 0x00000000, no tready, sequence unchanged afterwards.
REQ-031 SHALL cover: 9 consecutive non-idle frames -> sequence 0..7,0; and with `CMD_PARITY_EN every cmd_o has even parity, without it bit 31 is always 0.
REQ-032 SHALL cover: sysrst_n_i pulsed low at frame count 4 -> all outputs 0 immediately, and the next load cycle occurs 7 cycles after release.

Source files
------------

// File: rtl/surfturf_cmd_pkg.sv
// Shared field layout, widths and helpers for the surfturf command word builder.
// RACKBUS_RUNCMD_BITS / RACKBUS_TRIG_BITS normally come from rackbus.vh; defaults apply if absent.
`ifndef RACKBUS_RUNCMD_BITS
`define RACKBUS_RUNCMD_BITS 2
`endif
`ifndef RACKBUS_TRIG_BITS
`define RACKBUS_TRIG_BITS 15
`endif

package surfturf_cmd_pkg;
   localparam int RUNCMD_W  = `RACKBUS_RUNCMD_BITS;
   localparam int TRIG_W    = `RACKBUS_TRIG_BITS;
   localparam int FW_W      = 8;
   localparam int MARK_W    = 2;
   localparam int SEQ_W     = 3;
   localparam int CMD_W     = 32;
   localparam int CNT_W     = 8;

   localparam int TRIG_LSB    = 0;
   localparam int RUNCMD_LSB  = TRIG_LSB + TRIG_W;
   localparam int FW_LSB      = RUNCMD_LSB + RUNCMD_W;
   localparam int FW_PRES_BIT = FW_LSB + FW_W;
   localparam int MARK_LSB    = FW_PRES_BIT + 1;
   localparam int SEQ_LSB     = MARK_LSB + MARK_W;
   localparam int PAR_BIT     = SEQ_LSB + SEQ_W;

   localparam logic [CMD_W-1:0] IDLE_WORD = '0;

   // Field order mirrors the bit offsets above, MSB first.
   typedef struct packed {
      logic                par;
      logic [SEQ_W-1:0]    seq;
      logic [MARK_W-1:0]   mark;
      logic                fw_pres;
      logic [FW_W-1:0]     fw;
      logic [RUNCMD_W-1:0] runcmd;
      logic [TRIG_W-1:0]   trig;
   } cmd_word_t;

   // Bit that makes the full word even parity.
   function automatic logic even_par(input logic [CMD_W-2:0] v);
      return ^v;
   endfunction
endpackage

// File: rtl/surfturf_cmd_frame_timer.sv
// Free-running frame counter; load is high on the last cycle of each frame.
module surfturf_cmd_frame_timer
   import surfturf_cmd_pkg::*;
#(
   parameter int FRAME_LEN = 8
) (
   input  logic clk,
   input  logic rst_n,
   output logic load
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign load = (cnt == LAST);
endmodule

// File: rtl/surfturf_cmd_builder.sv
// Packs fw/runcmd/trig beats into one 32-bit command word per frame.
// Optional CMD_PARITY_EN: bit 31 makes the word even parity (0 when undefined).
module surfturf_cmd_builder
   import surfturf_cmd_pkg::*;
#(
   parameter int FRAME_LEN = 8
) (
   input  logic                sysclk_i,
   input  logic                sysrst_n_i,
   input  logic                disable_rxclk_i,
   input  logic [FW_W-1:0]     fw_tdata,
   input  logic                fw_tvalid,
   output logic                fw_tready,
   input  logic [MARK_W-1:0]   fw_mark_i,
   output logic                fw_marked_o,
   input  logic [RUNCMD_W-1:0] runcmd_tdata,
   input  logic                runcmd_tvalid,
   output logic                runcmd_tready,
   input  logic [TRIG_W-1:0]   trig_tdata,
   input  logic                trig_tvalid,
   output logic                trig_tready,
   output logic [CMD_W-1:0]    cmd_o,
   output logic                cmd_valid_o
);
   logic             load;
   logic             en;
   logic [SEQ_W-1:0] seq;
   cmd_word_t        word;

   surfturf_cmd_frame_timer #(.FRAME_LEN(FRAME_LEN)) u_timer (
      .clk   (sysclk_i),
      .rst_n (sysrst_n_i),
      .load  (load)
   );

   // Counter is cleared in reset, so load (and every tready) is low then too.
   assign en            = load & ~disable_rxclk_i;
   assign fw_tready     = en & fw_tvalid;
   assign runcmd_tready = en & runcmd_tvalid;
   assign trig_tready   = en & trig_tvalid;

   always_comb begin
      word = '0;
      if (trig_tready)   word.trig   = trig_tdata;
      if (runcmd_tready) word.runcmd = runcmd_tdata;
      if (fw_tready) begin
         word.fw      = fw_tdata;
         word.fw_pres = 1'b1;
      end
      word.mark = fw_mark_i;
      word.seq  = seq;
`ifdef CMD_PARITY_EN
      word.par  = even_par(word[CMD_W-2:0]);
`endif
   end

   always_ff @(posedge sysclk_i or negedge sysrst_n_i) begin
      if (!sysrst_n_i) begin
         seq         <= '0;
         cmd_o       <= IDLE_WORD;
         cmd_valid_o <= 1'b0;
         fw_marked_o <= 1'b0;
      end else begin
         cmd_valid_o <= load;
         fw_marked_o <= en & (|fw_mark_i);
         if (load) cmd_o <= en ? CMD_W'(word) : IDLE_WORD;
         // Disabled (idle) frames do not consume a sequence number.
         if (en) seq <= seq + 1'b1;
      end
   end
endmodule
